inject_sched: RTL

Injection scheduler for the per-node traffic-pattern buffers (`dataout_buf_*`). It drives each buffer's `enable`, throttles injection with per-node network ready, and counts each buffer's `out_valid` pulses against the expected burst length. It runs in one of two modes: sequential (one node at a time, round-robin, with an inter-burst gap) or concurrent (all nodes at once). It sits between the testbench/top-level control and the NoC injection ports and reports completion, progress and errors.

---
 rtl/noc_inject_pkg.sv | 23 ++
 rtl/inject_node_tracker.sv | 49 ++++
 rtl/inject_sched.sv | 119 +++++++++++
 3 files changed

// File: rtl/noc_inject_pkg.sv
// Shared types and sizing for the injection scheduler and its per-node trackers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_inject_pkg;

  localparam int N_NODES   = 16;
  localparam int BURST_LEN = 30;

  localparam int NODE_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int TOT_W  = $clog2(N_NODES * BURST_LEN + 1);

  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_CONC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/inject_node_tracker.sv
// Per-node word counter, idle timeout and spurious-valid detection for one buffer.
// Latency: counts register on the edge after buf_valid; complete_nxt is the look-ahead view.
// Backpressure: idle timer only advances while this node's enable is high.
module inject_node_tracker
  import noc_inject_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic legal,
  input  logic en,
  input  logic valid,
  output logic counted,
  output logic spurious,
  output logic timeout,
  output logic complete_nxt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]  cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              forced;
  logic              complete;

  assign complete = (cnt == CNT_W'(BURST_LEN)) || forced;
  assign counted  = run && valid && legal && !complete;
  assign spurious = run && valid && !(legal && !complete);
  // A valid arriving in the expiry cycle wins over the timeout.
  assign timeout  = run && en && !valid && !complete && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign complete_nxt = complete || timeout || (counted && (cnt == CNT_W'(BURST_LEN - 1)));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt      <= '0;
      idle_cnt <= '0;
      forced   <= 1'b0;
    end else begin
      if (counted) cnt <= cnt + CNT_W'(1);
      if (valid) idle_cnt <= '0;
      else if (en && !complete) idle_cnt <= idle_cnt + IDLE_W'(1);
      if (timeout) forced <= 1'b1;
    end
  end

endmodule

// File: rtl/inject_sched.sv
// Injection scheduler: enables per-node pattern buffers sequentially or concurrently and counts words.
// Latency: start -> busy after 1 edge, first enable after 2; net_ready -> buf_en 1 cycle.
// Backpressure: buf_en[k] follows net_ready[k] through one register; in-flight words still count.
module inject_sched
  import noc_inject_pkg::*;
#(
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [N_NODES-1:0] net_ready,
  input  logic [N_NODES-1:0] buf_valid,
  output logic [N_NODES-1:0] buf_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NODE_W-1:0]  cur_node,
  output logic [TOT_W-1:0]   total_cnt
);

  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  state_t             state, state_nxt;
  logic               mode_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [N_NODES-1:0] legal, counted, spurious, tmo, complete_nxt, en_d;
  logic               clear, run, gap_last, cur_done, all_done;
  logic [TOT_W-1:0]   add;

  assign clear    = (state == ST_IDLE) && start;
  assign run      = (state != ST_IDLE);
  assign busy     = (state == ST_RUN) || (state == ST_GAP);
  assign done     = (state == ST_DONE);
  assign gap_last = (int'(gap_cnt) + 1 >= GAP_CYC);
  assign cur_done = complete_nxt[cur_node];
  assign all_done = &complete_nxt;

  always_comb begin
    legal = '0;
    en_d  = '0;
    add   = '0;
    for (int k = 0; k < N_NODES; k++) begin
      legal[k] = (mode_q == MODE_CONC) || (NODE_W'(k) == cur_node);
      // Look-ahead completion drops the enable the cycle after the last word is counted.
      en_d[k]  = (state == ST_RUN) && legal[k] && net_ready[k] && !complete_nxt[k];
      add      = add + TOT_W'(counted[k]);
    end
  end

  for (genvar k = 0; k < N_NODES; k++) begin : g_trk
    inject_node_tracker #(.TIMEOUT(TIMEOUT)) u_trk (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .run          (run),
      .legal        (legal[k]),
      .en           (buf_en[k]),
      .valid        (buf_valid[k]),
      .counted      (counted[k]),
      .spurious     (spurious[k]),
      .timeout      (tmo[k]),
      .complete_nxt (complete_nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (mode_q == MODE_CONC) begin
          if (all_done) state_nxt = ST_DONE;
        end else if (cur_done) begin
          state_nxt = (cur_node == NODE_W'(N_NODES - 1)) ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP:  if (gap_last) state_nxt = ST_RUN;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_SEQ;
      cur_node  <= '0;
      gap_cnt   <= '0;
      buf_en    <= '0;
      err       <= 1'b0;
      total_cnt <= '0;
    end else begin
      buf_en <= en_d;
      err    <= err | (|(spurious | tmo));
      if (clear) begin
        mode_q    <= mode;
        cur_node  <= '0;
        gap_cnt   <= '0;
        total_cnt <= '0;
      end else begin
        total_cnt <= total_cnt + add;
      end
      if (state == ST_RUN) begin
        gap_cnt <= '0;
      end else if (state == ST_GAP) begin
        if (gap_last) cur_node <= cur_node + NODE_W'(1);
        else          gap_cnt  <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule
